tl_pass_ctrl: RTL and testbench

Request-side controller that drives the `pass` input of the traffic light FSM and observes its R/G/Y outputs.
- Takes an asynchronous, bouncy pre-emption button, synchronises and debounces it, and issues a single-cycle `pass` pulse when the light is not already green.
- Confirms that green follows the pulse, then enforces a cooldown before the next request.
- Also checks that exactly one lamp is lit.

---
 rtl/tl_pass_ctrl.sv | 177 +++++++++++++++++
 tb/tb_tl_pass_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_pass_ctrl.sv
// tl_pass_ctrl: request-side controller for the traffic light FSM.
// Conditions a bouncy pre-emption button into a single request event, issues a
// one-cycle pass pulse when the light is not green, confirms that green follows,
// then holds off further requests for a cooldown period. It also flags illegal
// lamp combinations.
module tl_pass_ctrl #(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 16,
   parameter int ACK_TIMEOUT  = 4,
   parameter int COOLDOWN_CYC = 2048,
   parameter int CNT_W        = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_btn,
   input  logic       R,
   input  logic       G,
   input  logic       Y,
   output logic       pass,
   output logic       req_pending,
   output logic       cooldown,
   output logic       light_err,
   output logic       ack_err,
   output logic [7:0] grant_cnt
);

   // Counters are loaded with (cycles - 1) and expire at zero.
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] ACK_LD  = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOLDOWN_CYC - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PENDING,
      S_PASS,
      S_WAIT_G,
      S_COOLDOWN
   } state_t;

   state_t                 state, state_nx;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   R_s, G_s, Y_s;
   logic                   lamp_vld;
   logic [1:0]             lamp_sum;
   logic                   lamp_legal;
   logic                   db_lvl, db_lvl_q;
   logic [CNT_W-1:0]       db_cnt;
   logic                   req_evt;
   logic [CNT_W-1:0]       cnt, cnt_nx;
   logic                   latch, latch_nx;
   logic                   grant_inc, ack_to;

   // Synchronise the button and register the lamps once; lamp_vld marks that
   // R_s/G_s/Y_s hold a real sample, so the cleared post-reset copies are not
   // mistaken for an illegal (all-dark) combination.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= '0;
         R_s      <= 1'b0;
         G_s      <= 1'b0;
         Y_s      <= 1'b0;
         lamp_vld <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], req_btn};
         R_s      <= R;
         G_s      <= G;
         Y_s      <= Y;
         lamp_vld <= 1'b1;
      end
   end

   assign lamp_sum   = {1'b0, R_s} + {1'b0, G_s} + {1'b0, Y_s};
   assign lamp_legal = (lamp_sum == 2'd1);

   // Debounce: count consecutive samples that disagree with the level and
   // toggle the level on the DEBOUNCE_CYC-th one; any agreeing sample restarts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_lvl   <= 1'b0;
         db_lvl_q <= 1'b0;
         db_cnt   <= '0;
      end else begin
         db_lvl_q <= db_lvl;
         if (sync_q[SYNC_STAGES-1] != db_lvl) begin
            if (db_cnt == DB_LAST) begin
               db_lvl <= ~db_lvl;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + ONE;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign req_evt = db_lvl & ~db_lvl_q;

   // State, shared down-counter, one-deep request latch and the pass pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         latch <= 1'b0;
         pass  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         latch <= latch_nx;
         pass  <= (state_nx == S_PASS);
      end
   end

   // Next-state logic; the counter is reloaded on entry to WAIT_G and COOLDOWN.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      latch_nx  = latch;
      grant_inc = 1'b0;
      ack_to    = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_evt && !G_s) state_nx = S_PENDING;
         end
         S_PENDING: begin
            if (G_s)             state_nx = S_IDLE;
            else if (lamp_legal) state_nx = S_PASS;
         end
         S_PASS: begin
            state_nx = S_WAIT_G;
            cnt_nx   = ACK_LD;
         end
         S_WAIT_G: begin
            if (G_s) begin
               grant_inc = 1'b1;
               state_nx  = S_COOLDOWN;
               cnt_nx    = COOL_LD;
            end else if (cnt == '0) begin
               ack_to   = 1'b1;
               state_nx = S_COOLDOWN;
               cnt_nx   = COOL_LD;
            end else begin
               cnt_nx = cnt - ONE;
            end
         end
         S_COOLDOWN: begin
            if (cnt == '0) begin
               // an event on the expiry cycle still counts as latched
               state_nx = (latch || req_evt) ? S_PENDING : S_IDLE;
               latch_nx = 1'b0;
            end else begin
               cnt_nx = cnt - ONE;
               if (req_evt) latch_nx = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Sticky error flags and the saturating grant counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         light_err <= 1'b0;
         ack_err   <= 1'b0;
         grant_cnt <= 8'd0;
      end else begin
         if (lamp_vld && !lamp_legal) light_err <= 1'b1;
         if (ack_to)                  ack_err   <= 1'b1;
         if (grant_inc && grant_cnt != 8'hFF) grant_cnt <= grant_cnt + 8'd1;
      end
   end

   assign req_pending = (state == S_PENDING) | latch;
   assign cooldown    = (state == S_COOLDOWN);

endmodule

// File: tb/tb_tl_pass_ctrl.sv
// tb_tl_pass_ctrl: scoreboard bench for tl_pass_ctrl. A deadline-based reference
// model predicts the edge of every pass pulse and the status outputs; a monitor
// on the falling edge pops and compares whenever pass is presented.
module tb_tl_pass_ctrl;
   localparam int SYNC_STAGES  = 2;
   localparam int DEBOUNCE_CYC = 16;
   localparam int ACK_TIMEOUT  = 4;
   localparam int COOLDOWN_CYC = 2048;
   localparam int CNT_W        = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_btn = 1'b0;
   logic       R = 1'b1, G = 1'b0, Y = 1'b0;
   logic       pass, req_pending, cooldown, light_err, ack_err;
   logic [7:0] grant_cnt;

   tl_pass_ctrl #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .COOLDOWN_CYC(COOLDOWN_CYC),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_btn    (req_btn),
      .R          (R),
      .G          (G),
      .Y          (Y),
      .pass       (pass),
      .req_pending(req_pending),
      .cooldown   (cooldown),
      .light_err  (light_err),
      .ack_err    (ack_err),
      .grant_cnt  (grant_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   int exp_q[$];

   // reference model: phase plus absolute deadlines instead of counters
   typedef enum int {M_IDLE, M_WANT, M_FIRE, M_ACK, M_REST} mphase_t;
   mphase_t m_ph;
   int      m_since;
   bit      m_latch, m_lerr, m_aerr;
   int      m_grant;
   bit      bq[$];
   bit      m_lvl, m_ev;
   int      m_run;
   bit      lp_r, lp_g, lp_y, lp_vld;

   // reactive traffic-light environment
   bit ack_en = 1'b1;
   int ack_dly = 1;
   int g_cd = 0, g_hold = 0;

   // monitor statistics
   int pass_total = 0, last_pass = -1, cool_cnt = 0, pend_cnt = 0, cool_fall = -1;
   bit pend_in_cool = 1'b0, prev_cool = 1'b0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_ph = M_IDLE; m_since = 0; m_latch = 0; m_lerr = 0; m_aerr = 0; m_grant = 0;
      bq.delete();
      for (int i = 0; i < SYNC_STAGES; i++) bq.push_back(1'b0);
      m_lvl = 0; m_run = 0; m_ev = 0;
      lp_r = 0; lp_g = 0; lp_y = 0; lp_vld = 0;
      exp_q.delete();
   endtask

   // One clock edge of the reference, using the inputs the DUT sampled.
   task automatic model_edge();
      bit legal, s, ev;
      if (rst) begin
         model_reset();
         return;
      end
      legal = (int'(lp_r) + int'(lp_g) + int'(lp_y)) == 1;
      if (lp_vld && !legal) m_lerr = 1;
      ev = m_ev;
      case (m_ph)
         M_IDLE: if (ev && !lp_g) m_ph = M_WANT;
         M_WANT: begin
            if (lp_g) m_ph = M_IDLE;
            else if (legal) begin
               m_ph = M_FIRE;
               exp_q.push_back(cyc);
            end
         end
         M_FIRE: begin m_ph = M_ACK; m_since = cyc; end
         M_ACK: begin
            if (lp_g) begin
               if (m_grant < 255) m_grant++;
               m_ph = M_REST; m_since = cyc;
            end else if (cyc - m_since >= ACK_TIMEOUT) begin
               m_aerr = 1; m_ph = M_REST; m_since = cyc;
            end
         end
         M_REST: begin
            if (ev) m_latch = 1;
            if (cyc - m_since >= COOLDOWN_CYC) begin
               m_ph = m_latch ? M_WANT : M_IDLE;
               m_latch = 0;
            end
         end
         default: m_ph = M_IDLE;
      endcase
      s = bq.pop_front();
      bq.push_back(req_btn);
      m_ev = 0;
      if (s != m_lvl) begin
         m_run++;
         if (m_run == DEBOUNCE_CYC) begin
            m_lvl = s; m_run = 0; m_ev = s;
         end
      end else begin
         m_run = 0;
      end
      lp_r = R; lp_g = G; lp_y = Y; lp_vld = 1;
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      if (g_cd > 0) begin
         g_cd--;
         if (g_cd == 0) begin R = 0; G = 1; Y = 0; g_hold = 12; end
      end else if (g_hold > 0) begin
         g_hold--;
         if (g_hold == 0) begin G = 0; R = 1; end
      end
      if (pass && ack_en && g_cd == 0 && g_hold == 0) g_cd = ack_dly;
   endtask

   task automatic press(input int len);
      req_btn = 1'b1;
      repeat (len) step();
      req_btn = 1'b0;
   endtask

   task automatic do_reset_chk();
      rst = 1'b1;
      model_reset();
      g_cd = 0; g_hold = 0; R = 1; G = 0; Y = 0;
      step();
      check("reset_outputs", int'({pass, req_pending, cooldown, light_err, ack_err, grant_cnt}), 0);
      step();
      rst = 1'b0;
   endtask

   // Monitor: pops an expected pass edge whenever the DUT presents pass.
   always @(negedge clk) begin : mon
      logic [11:0] act_v, req_v;
      int e;
      if (pass) begin
         pass_total++;
         last_pass = cyc;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL pass_unexpected: pass=1 after edge %0d, required pass=0", cyc);
         end else begin
            e = exp_q.pop_front();
            if (e != cyc) begin
               n_bad++;
               $display("FAIL pass_time: pass after edge %0d, required after edge %0d", cyc, e);
            end
         end
      end
      act_v = {req_pending, cooldown, light_err, ack_err, grant_cnt};
      req_v = {((m_ph == M_WANT) || m_latch), (m_ph == M_REST), m_lerr, m_aerr, 8'(m_grant)};
      n_cmp++;
      if (act_v != req_v) begin
         n_bad++;
         $display("FAIL status@%0d: {pend,cool,lerr,aerr,grant} got %h, required %h", cyc, act_v, req_v);
      end
      if (cooldown) cool_cnt++;
      if (req_pending) pend_cnt++;
      if (req_pending && cooldown) pend_in_cool = 1'b1;
      if (prev_cool && !cooldown) cool_fall = cyc;
      prev_cool = cooldown;
   end

   initial begin
      int e0, p0, g0;
      model_reset();
      rst = 1'b1;
      repeat (3) step();
      check("reset_outputs", int'({pass, req_pending, cooldown, light_err, ack_err, grant_cnt}), 0);
      rst = 1'b0;
      repeat (5) step();

      // clean press, green one cycle after pass
      cool_cnt = 0; p0 = pass_total; e0 = cyc;
      press(40);
      repeat (2100) step();
      check("s2_pass_edge", last_pass, e0 + 20);
      check("s2_pass_count", pass_total - p0, 1);
      check("s2_grant", int'(grant_cnt), 1);
      check("s2_cool_len", cool_cnt, COOLDOWN_CYC);

      // second press during cooldown is latched and served after expiry
      g0 = int'(grant_cnt); p0 = pass_total; pend_in_cool = 1'b0;
      press(40);
      repeat (400) step();
      press(40);
      check("s5_pending_in_cool", int'(pend_in_cool), 1);
      cool_fall = -1;
      repeat (1700) step();
      check("s5_pass_after_expiry", last_pass, cool_fall + 1);
      check("s5_grant", int'(grant_cnt), g0 + 2);
      check("s5_pass_count", pass_total - p0, 2);
      repeat (2100) step();

      // 10-high / 10-low toggling never debounces
      p0 = pass_total; pend_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         req_btn = 1'b1; repeat (10) step();
         req_btn = 1'b0; repeat (10) step();
      end
      repeat (30) step();
      check("s3_no_pass", pass_total - p0, 0);
      check("s3_no_pending", pend_cnt, 0);

      // green already on: request absorbed
      R = 0; G = 1; g0 = int'(grant_cnt); p0 = pass_total; pend_cnt = 0; cool_cnt = 0;
      press(40);
      repeat (40) step();
      check("s4_no_pass", pass_total - p0, 0);
      check("s4_grant", int'(grant_cnt), g0);
      check("s4_idle", pend_cnt + cool_cnt, 0);
      G = 0; R = 1;
      repeat (5) step();

      // R and G together for one cycle
      G = 1; step(); G = 0;
      repeat (3) step();
      check("s6_light_err", int'(light_err), 1);
      repeat (20) step();
      check("s6_light_err_sticky", int'(light_err), 1);

      // no green after pass: timeout
      ack_en = 1'b0; g0 = int'(grant_cnt); cool_cnt = 0;
      press(40);
      repeat (2100) step();
      check("s6_ack_err", int'(ack_err), 1);
      check("s6_ack_grant", int'(grant_cnt), g0);
      check("s6_ack_cool", cool_cnt, COOLDOWN_CYC);
      ack_en = 1'b1;

      // reset mid-cooldown with the latch set, then quiet
      press(40);
      repeat (400) step();
      press(40);
      repeat (10) step();
      check("s1_latched", int'({req_pending, cooldown}), 3);
      do_reset_chk();
      p0 = pass_total;
      repeat (3000) step();
      check("s1_no_pass", pass_total - p0, 0);

      // randomized episodes
      for (int ep = 0; ep < 8; ep++) begin
         bit gsteady;
         ack_en  = ($urandom_range(0, 4) != 0);
         ack_dly = int'($urandom_range(1, 6));
         gsteady = ($urandom_range(0, 5) == 0) && g_cd == 0 && g_hold == 0;
         if (gsteady) begin R = 0; G = 1; end
         repeat ($urandom_range(0, 8)) begin req_btn = 1'($urandom_range(0, 1)); step(); end
         req_btn = 1'b1;
         repeat ($urandom_range(5, 60)) step();
         repeat ($urandom_range(0, 8)) begin req_btn = 1'($urandom_range(0, 1)); step(); end
         req_btn = 1'b0;
         if ($urandom_range(0, 3) == 0) begin Y = 1; step(); Y = 0; end
         repeat ($urandom_range(10, 60)) step();
         if (gsteady && g_cd == 0 && g_hold == 0) begin G = 0; R = 1; end
         repeat ($urandom_range(100, 2300)) step();
      end
      ack_en = 1'b1;
      repeat (2300) step();
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
